// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter and burst sequencer for a shared 4:1 datapath mux
//
// mux4 : combinational 4:1 word mux, y_o = d[s_i]
//
// mux4_rr_arbiter : owns the mux select, grants one requester at a time and
// streams the owner's words to a valid/ready sink, rotating ownership after
// at most BURST accepted words or as soon as the owner drops its request.
//   clk_i      rising-edge clock
//   reset_i    asynchronous active-high reset
//   req_i      per-requester request lines
//   d0_i..d3_i requester data words
//   y_ready_i  sink accepts y_o this cycle
//   y_valid_o  y_o holds a valid word
//   y_o        muxed data, d[s_o]
//   s_o        registered mux select (owner index)
//   gnt_o      registered one-hot grant, zero when idle
//   ack_o      one-hot pulse, owner's word accepted this cycle

module mux4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  input  logic [1:0]       s_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (s_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [3:0]       req_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  input  logic             y_ready_i,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_o,
  output logic [1:0]       s_o,
  output logic [3:0]       gnt_o,
  output logic [3:0]       ack_o
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    s_q, s_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;

  logic          xfer;
  logic          rel;
  logic          any_req;
  logic [1:0]    win_ptr;
  logic [1:0]    win_own;

  // Scan base+1 .. base+4 (mod 4); base itself is visited last, so the
  // previous owner only wins when nobody else is asking.
  function automatic logic [1:0] win(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    win   = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .d0_i (d0_i),
    .d1_i (d1_i),
    .d2_i (d2_i),
    .d3_i (d3_i),
    .s_i  (s_q),
    .y_o  (y_o)
  );

  // Only the owner's request line feeds the outputs; the others are looked
  // at solely when ownership changes hands.
  assign y_valid_o = (state_q == BUSY) & req_i[s_q];
  assign xfer      = y_valid_o & y_ready_i;
  assign ack_o     = gnt_q & {4{xfer}};
  assign s_o       = s_q;
  assign gnt_o     = gnt_q;

  assign any_req   = |req_i;
  assign win_ptr   = win(ptr_q, req_i);
  assign win_own   = win(s_q, req_i);
  assign rel       = ~req_i[s_q] | (xfer & (cnt_q == CNT_LAST));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          s_d     = win_ptr;
          gnt_d   = onehot(win_ptr);
          cnt_d   = '0;
        end
      end
      default: begin
        if (rel) begin
          ptr_d = s_q;
          if (any_req) begin
            // Hand over without an idle cycle in between.
            s_d   = win_own;
            gnt_d = onehot(win_own);
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // ptr resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      s_q     <= 2'd0;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed table-driven bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] req_i;
  logic [3:0] d0_i, d1_i, d2_i, d3_i;
  logic       y_ready_i;
  logic       y_valid_o;
  logic [3:0] y_o;
  logic [1:0] s_o;
  logic [3:0] gnt_o;
  logic [3:0] ack_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(4), .BURST(4)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .d0_i      (d0_i),
    .d1_i      (d1_i),
    .d2_i      (d2_i),
    .d3_i      (d3_i),
    .y_ready_i (y_ready_i),
    .y_valid_o (y_valid_o),
    .y_o       (y_o),
    .s_o       (s_o),
    .gnt_o     (gnt_o),
    .ack_o     (ack_o)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       yv;
    logic [3:0] y;
    logic [3:0] ack;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic rdy,
                     input logic [3:0] gnt, input logic [1:0] s, input logic yv,
                     input logic [3:0] y, input logic [3:0] ack, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy; v.gnt = gnt; v.s = s;
    v.yv = yv; v.y = y; v.ack = ack; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i   = 1'b1;
    req_i     = 4'b0000;
    y_ready_i = 1'b0;
    tick();
    reset_i   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] gnt, input logic [1:0] s,
                         input logic yv, input logic [3:0] y, input logic [3:0] ack);
    chk({tag, ".gnt"}, 32'(gnt_o), 32'(gnt));
    chk({tag, ".s"}, 32'(s_o), 32'(s));
    chk({tag, ".y_valid"}, 32'(y_valid_o), 32'(yv));
    chk({tag, ".y"}, 32'(y_o), 32'(y));
    chk({tag, ".ack"}, 32'(ack_o), 32'(ack));
  endtask

  logic [3:0] dval [4];

  initial begin
    dval[0] = 4'h9; dval[1] = 4'h2; dval[2] = 4'h3; dval[3] = 4'h5;
    d0_i = dval[0]; d1_i = dval[1]; d2_i = dval[2]; d3_i = dval[3];
    reset_i = 1'b1; req_i = 4'b0000; y_ready_i = 1'b0;

    // Reset, then a solo requester 2 burst with seamless re-grant.
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 4'h9, 4'b0000, 0);
    add(0, 4'b0100, 1, 4'b0000, 0, 0, 4'h9, 4'b0000, 0);
    for (int c = 0; c < 4; c++)
      add(0, 4'b0100, 1, 4'b0100, 2, 1, 4'h3, 4'b0100, 3'(c));
    add(0, 4'b0100, 1, 4'b0100, 2, 1, 4'h3, 4'b0100, 0);
    // Owner 2 drops, requester 1 takes over, then reset lands mid-burst.
    add(0, 4'b0010, 1, 4'b0100, 2, 0, 4'h3, 4'b0000, 1);
    add(0, 4'b0010, 1, 4'b0010, 1, 1, 4'h2, 4'b0010, 0);
    add(1, 4'b0010, 1, 4'b0000, 0, 0, 4'h9, 4'b0000, 0);
    // All requesting: requester 0 first, then 1,2,3,0 with 4 beats each.
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 4'h9, 4'b0000, 0);
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 4; c++)
        add(0, 4'b1111, 1, 4'b0001 << o, 2'(o), 1, dval[o], 4'b0001 << o, 3'(c));
    add(0, 4'b1111, 1, 4'b0001, 0, 1, 4'h9, 4'b0001, 0);

    foreach (vecs[i]) begin
      reset_i   = vecs[i].rst;
      req_i     = vecs[i].req;
      y_ready_i = vecs[i].rdy;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].s, vecs[i].yv, vecs[i].y, vecs[i].ack);
      chk($sformatf("vec%0d.cnt", i), 32'(dut.cnt_q), 32'(vecs[i].cnt));
      tick();
    end

    // Stall: requester 3 holds the grant while the sink is not ready.
    d3_i = 4'h1;
    do_reset();
    req_i = 4'b1000; y_ready_i = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      chk_out($sformatf("stall%0d", k), 4'b1000, 3, 1, 4'h1, 4'b0000);
      chk($sformatf("stall%0d.cnt", k), 32'(dut.cnt_q), 32'd0);
      tick();
    end
    y_ready_i = 1'b1;
    #1;
    chk_out("stall_resume", 4'b1000, 3, 1, 4'h1, 4'b1000);
    tick();
    chk("stall_resume.cnt", 32'(dut.cnt_q), 32'd1);
    d3_i = dval[3];

    // Early drop: owner 1 leaves after 2 beats, requester 0 waiting.
    do_reset();
    req_i = 4'b0010; y_ready_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk_out($sformatf("drop_beat%0d", k), 4'b0010, 1, 1, 4'h2, 4'b0010);
      tick();
    end
    req_i = 4'b0001;
    #1;
    chk_out("drop_cycle", 4'b0010, 1, 0, 4'h2, 4'b0000);
    tick();
    chk_out("drop_next", 4'b0001, 0, 1, 4'h9, 4'b0001);
    chk("drop_next.ptr", 32'(dut.ptr_q), 32'd1);
    chk("drop_next.cnt", 32'(dut.cnt_q), 32'd0);

    // Idle: owner 2 releases with nobody requesting; s keeps its value.
    do_reset();
    req_i = 4'b0100; y_ready_i = 1'b1;
    tick();
    chk_out("idle_own", 4'b0100, 2, 1, 4'h3, 4'b0100);
    tick();
    req_i = 4'b0000;
    tick();
    chk_out("idle_a", 4'b0000, 2, 0, 4'h3, 4'b0000);
    tick();
    chk_out("idle_b", 4'b0000, 2, 0, 4'h3, 4'b0000);
    req_i = 4'b0001;
    #1;
    chk_out("idle_req", 4'b0000, 2, 0, 4'h3, 4'b0000);
    tick();
    chk_out("idle_grant", 4'b0001, 0, 1, 4'h9, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
